// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, fetch FSM states and instruction-queue entry.
package cpu_pkg;

   localparam int INSTR_W    = 32;
   localparam int WORD_BYTES = 4;
   localparam int PC_W       = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: synchronous FIFO of DEPTH entries; clear wins over push and pop.
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues 1-cycle-latency insmem reads and queues
// returned words for decode; redirects flush the queue and stale fetches.
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_rd_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic               instr_valid,
   output logic [31:0]        instr,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt,
   output logic               misalign_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t      state;
   fetch_state_t      state_nx;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] tag_pc;
   logic              inflight;
   logic              epoch;
   logic              tag_epoch;
   logic              issue;
   logic              push;
   logic              pop;
   logic              empty;
   logic              full;
   logic [CW-1:0]     count;
   logic [CW:0]       used;
   fetch_entry_t      wr_entry;
   fetch_entry_t      rd_entry;

   assign pop  = instr_ready && !empty;
   assign push = inflight && tag_epoch == epoch;
   // Slots still committed after this cycle's pop; a same-cycle pop frees a
   // slot so the pipe sustains one fetch per cycle while decode keeps up.
   assign used = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

   always_comb begin
      state_nx = halt ? HALT : RUN;
      issue    = state == RUN && !halt && !redirect_valid && !(full && !pop) &&
                 used < (CW+1)'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         tag_pc       <= '0;
         inflight     <= 1'b0;
         epoch        <= 1'b0;
         tag_epoch    <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (issue) begin
            tag_pc    <= pc;
            tag_epoch <= epoch;
         end
         if (redirect_valid) begin
            pc           <= {redirect_pc[ADDR_W-1:2], 2'b00};
            epoch        <= ~epoch;
            misalign_err <= misalign_err | (redirect_pc[1:0] != 2'b00);
         end else if (issue) begin
            pc <= pc + ADDR_W'(WORD_BYTES);
         end
      end
   end

   assign wr_entry = '{instr: imem_rdata, pc: PC_W'(tag_pc)};

   fetch_buf #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (redirect_valid),
      .din   (wr_entry),
      .dout  (rd_entry),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   assign imem_rd_en  = issue;
   assign imem_addr   = pc;
   assign instr_valid = !empty;
   assign instr       = empty ? '0 : rd_entry.instr;
   assign instr_pc    = empty ? '0 : rd_entry.pc[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: program-order scoreboard bench for fetch_ctrl with randomized traffic.
module tb_fetch_ctrl;

   localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;
   logic        misalign_err;

   always #5 clk = ~clk;

   fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_rd_en     (imem_rd_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .misalign_err   (misalign_err)
   );

   // instruction memory: word at address a is a ^ KEY, one cycle after the strobe
   always @(posedge clk) imem_rdata <= imem_rd_en ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_pop = 0;
   int          pop_a = 0;
   int          pop_b = 0;
   logic [31:0] exp_q[$];
   logic [31:0] tail;
   logic [31:0] nf;
   logic        mis_exp = 1'b0;
   logic        prev_redirect = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] held_i;
   logic [31:0] held_pc;
   logic        done = 1'b0;
   logic        fin = 1'b0;
   logic        timeout = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back(tail);
         tail = tail + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] base);
      exp_q.delete();
      tail = base;
      nf   = base;
      refill();
   endtask

   // monitor: program order restarts at each redirect/reset; everything else is sequential words
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ctl", {61'd0, imem_rd_en, instr_valid, misalign_err}, 64'd0);
         chk("rst_instr", {instr, instr_pc}, 64'd0);
         chk("rst_addr", imem_addr, RST_PC);
         restart(RST_PC);
         mis_exp       = 1'b0;
         prev_redirect = 1'b0;
         prev_hold     = 1'b0;
      end else begin
         if (imem_rd_en) begin
            chk("fetch_addr", imem_addr, nf);
            nf = nf + 32'd4;
         end
         if (redirect_valid || halt) chk("no_issue", imem_rd_en, 0);
         if (prev_redirect) chk("flush_valid", instr_valid, 0);
         if (prev_hold) begin
            chk("hold_valid", instr_valid, 1);
            chk("hold_data", {instr_pc, instr}, {held_pc, held_i});
         end
         if (instr_valid && instr_ready && !redirect_valid) begin
            chk("pop_pc", instr_pc, exp_q[0]);
            chk("pop_instr", instr, exp_q[0] ^ KEY);
            void'(exp_q.pop_front());
            refill();
            n_pop++;
         end
         if (!redirect_valid) chk("misalign", misalign_err, mis_exp);
         if (redirect_valid) begin
            restart({redirect_pc[31:2], 2'b00});
            mis_exp = mis_exp | (redirect_pc[1:0] != 2'b00);
         end
         prev_hold     = instr_valid && !instr_ready && !redirect_valid;
         held_i        = instr;
         held_pc       = instr_pc;
         prev_redirect = redirect_valid;
      end
      if (done && !fin) begin
         chk("throughput", 64'(pop_b - pop_a), 64'd10);
         chk("progress", 64'(n_pop >= 100), 64'd1);
         chk("wait_timeout", timeout, 0);
         fin = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();
      pop_a = n_pop;
      repeat (10) step();
      pop_b = n_pop;
      instr_ready = 1'b0;
      repeat (6) step();
      instr_ready = 1'b1;
      repeat (6) step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (imem_rd_en && imem_addr == 32'h0000_000C) break;
         if (i == 49) timeout = 1'b1;
      end
      step();
      redir(32'h0000_0100);
      repeat (8) step();
      redir(32'h0000_0102);
      repeat (8) step();
      halt = 1'b1;
      instr_ready = 1'b0;
      repeat (3) step();
      instr_ready = 1'b1;
      repeat (3) step();
      halt = 1'b0;
      repeat (8) step();
      redir(32'hFFFF_FFF8);
      repeat (8) step();
      #2 rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 600; i++) begin
         instr_ready    = $urandom_range(0, 9) < 7;
         redirect_valid = $urandom_range(0, 24) == 0;
         redirect_pc    = $urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 255)) : $urandom();
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            repeat (2) step();
            rst_n = 1'b1;
         end
         step();
      end
      halt = 1'b0;
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      repeat (10) step();
      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the CPU. It owns the program counter and issues read requests to the instruction memory (insmem, 1-cycle read latency). It buffers returned words with their PC in a small queue and hands them to decode over a valid/ready handshake. Decode or branch logic can redirect the PC at any time; a redirect flushes all stale fetches.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h00000000, first fetch address after reset
DEPTH, 2, instruction queue entries; power of two, minimum 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_rd_en  out  1  read strobe to instruction memory
imem_addr  out  ADDR_W  read address; always word aligned
imem_rdata  in  32  read data, valid exactly 1 cycle after imem_rd_en
instr_valid  out  1  queue head holds a valid instruction
instr  out  32  instruction word at queue head
instr_pc  out  ADDR_W  PC of instr
instr_ready  in  1  decode accepts the head this cycle
redirect_valid  in  1  single-cycle PC redirect (branch or jump)
redirect_pc  in  ADDR_W  redirect target
halt  in  1  level: while high, no new fetches are issued
misalign_err  out  1  sticky flag; set by a redirect whose target has bits [1:0] != 0

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. While rst_n=0: PC=RESET_PC, state=BOOT, queue empty, no fetch in flight. All outputs are 0 during reset except imem_addr, which equals RESET_PC.
- FSM states:
  - BOOT: lasts one cycle after reset release; no issue. Moves to RUN, or to HALT if halt=1.
  - RUN: issues fetches. Moves to HALT when halt=1.
  - HALT: no issue. Returns to RUN when halt=0.
  - Changing state never discards queued or in-flight data.
- Issue rule: in RUN, imem_rd_en=1 when (queue count + inflight) < DEPTH and redirect_valid=0.
  - imem_addr=PC.
  - On issue: PC <= PC+4, modulo 2^ADDR_W (32'hFFFFFFFC wraps to 0); inflight <= 1; the tag PC is recorded.
  - Throughput is one fetch per cycle when the queue drains every cycle. Fetch-to-instr_valid latency is 2 cycles (issue, then data written into the queue).
- Response: the cycle after an issue, {imem_rdata, tag PC} is pushed into the queue, unless a flush occurred in between.
- Pop: occurs when instr_valid && instr_ready. A push and a pop in the same cycle are both performed. Credit accounting guarantees the queue never overflows.
- Redirect (highest priority):
  - PC <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - The queue is cleared, including a same-cycle push. A same-cycle pop is ignored, and instr_valid is 0 from the next cycle.
  - Any in-flight response is dropped via an epoch bit that toggles on redirect.
  - No issue in the redirect cycle; first fetch from the new PC follows in the next cycle if in RUN.
  - A redirect in HALT or BOOT updates PC and flushes but does not change state.
  - misalign_err <= 1 if redirect_pc[1:0] != 0; cleared only by reset.
- halt does not flush: queued instructions remain poppable, and an in-flight response still lands.
- Reset asserted mid-operation: everything returns to reset values immediately; an in-flight response arriving after reset release is ignored.
- instr and instr_pc hold their value while instr_valid=1 && instr_ready=0.

Decomposition:
- Shared cpu_pkg: INSTR_W=32, WORD_BYTES=4, default RESET_PC, the fetch_state_t enum {BOOT, RUN, HALT}, and the queue entry struct {instr, pc}.
- Sub-module fetch_buf: synchronous FIFO of DEPTH entries with push, pop, clear, count, and empty/full outputs; clear overrides push.
- FSM, PC, credit and epoch logic stay in fetch_ctrl.

Test Plan:
- Reset then run, instr_ready=1, memory returns addr^32'hA5A5A5A5 → imem_addr sequence 0,4,8,…; first instr_valid 2 cycles after BOOT with instr_pc=0; then one instruction per cycle.
- Backpressure: instr_ready=0 from cycle 5 → at most DEPTH=2 entries queued, imem_rd_en drops to 0, instr and instr_pc stable; on release, PCs continue without gap or duplicate.
- Redirect to 32'h100 while a fetch of 32'h0C is in flight → 32'h0C never appears; next imem_addr=32'h100; next instr_pc=32'h100.
- Redirect to 32'h102 → misalign_err=1 and stays set; fetch from 32'h100.
- halt=1 with 1 queued and 1 in flight → no new issue; both instructions delivered in order; halt=0 resumes at the correct PC.
- Wrap-around: redirect to 32'hFFFFFFF8 → fetches FFFFFFF8, FFFFFFFC, 00000000. Separately, assert rst_n low mid-stream → outputs clear asynchronously, and the first fetch after release is RESET_PC.
